// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack side, decode valid/ready side, redirect.
// Latency: none (wires only).
// Backpressure: inst_ready stalls the decode side; mem_ack paces the memory side.
interface inst_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

  // Memory / decode / branch side
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Sequential instruction fetch with a small prefetch FIFO and branch redirect/flush.
// Latency: a word acked at cycle k is presented to decode at k+1; one request outstanding.
// Backpressure: inst_ready low fills the FIFO, after which no new request is issued.
module inst_fetch #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              push, pop, flush, has_room;
  logic [CNT_W-1:0]  cnt_next;

  // FIFO traffic this cycle; redirect squashes both push and pop and empties the buffer
  always_comb begin
    flush    = bus.redirect;
    pop      = (cnt_q != '0) && bus.inst_ready && !bus.redirect;
    push     = (state_q == WAIT) && bus.mem_ack && !bus.redirect;
    cnt_next = flush ? '0 : (cnt_q + CNT_W'(push) - CNT_W'(pop));
    has_room = (cnt_next < DEPTH_C);
  end

  // Fetch sequencer: decides next state, next fetch PC and the address to present
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (has_room) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = bus.mem_ack ? IDLE : DROP;
        end else if (bus.mem_ack) begin
          fetch_pc_d = addr_q + ADDR_W'(1);
          if (has_room) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // the in-flight request must still be held until its ack, then its data is thrown away
        if (bus.redirect) fetch_pc_d = bus.redirect_pc;
        if (bus.mem_ack)  state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // Prefetch FIFO storage and pointers; entries carry the word and its address
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        dat_q[wr_ptr_q] <= bus.mem_rdata;
        pc_q[wr_ptr_q]  <= addr_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_next;
    end
  end

  assign bus.mem_req    = (state_q != IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.inst_valid = (cnt_q != '0);
  assign bus.inst       = dat_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by randomized traffic.
// A delivery-order scoreboard tracks the expected next PC from resets and redirects only.
// Memory model responds with a programmable or random latency; rdata = addr ^ 16'hA500.
module tb_inst_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] XMASK    = 16'hA500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  inst_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int   lat_fixed = 0;
  int   lat_rnd   = 0;
  bit   rand_mode = 1'b0;
  int   wait_cnt  = 0;
  logic stray_ack = 1'b0;
  int   cur_lat;

  assign cur_lat       = rand_mode ? lat_rnd : lat_fixed;
  assign bus.mem_ack   = (bus.mem_req && (wait_cnt >= cur_lat)) || stray_ack;
  assign bus.mem_rdata = bus.mem_addr ^ XMASK;

  always @(posedge clk) begin
    if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                                      wait_cnt <= wait_cnt + 1;
    if (bus.mem_ack) lat_rnd <= int'($urandom_range(0, 3));
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_pc    = RESET_PC;
  logic        redir_prev = 1'b0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [15:0] prev_addr = '0;
  int          idle_cyc  = 0;
  logic [15:0] deliv_q [$];

  always @(negedge clk) begin
    if (reset) begin
      exp_pc     <= RESET_PC;
      redir_prev <= 1'b0;
      prev_req   <= 1'b0;
      prev_ack   <= 1'b0;
      idle_cyc   <= 0;
    end else begin
      if (redir_prev) chk("flush_valid", 32'(bus.inst_valid), 32'(0));
      if (prev_req && !prev_ack) begin
        chk("req_hold",  32'(bus.mem_req),  32'(1));
        chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
      end
      if (bus.redirect) begin
        exp_pc   <= bus.redirect_pc;
        idle_cyc <= 0;
      end else if (bus.inst_valid && bus.inst_ready) begin
        chk("deliv_pc",   32'(bus.inst_pc), 32'(exp_pc));
        chk("deliv_inst", 32'(bus.inst),    32'(exp_pc ^ XMASK));
        deliv_q.push_back(bus.inst_pc);
        exp_pc   <= exp_pc + 16'd1;
        idle_cyc <= 0;
      end else if (idle_cyc > 60) begin
        chk("stall_watchdog", 32'(idle_cyc), 32'(0));
        idle_cyc <= 0;
      end else begin
        idle_cyc <= idle_cyc + 1;
      end
      redir_prev <= bus.redirect;
      prev_req   <= bus.mem_req;
      prev_ack   <= bus.mem_ack;
      prev_addr  <= bus.mem_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.redirect = 1'b0;
    stray_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input int budget, input string tag);
    settle();
    for (int i = 0; i < budget; i++) begin
      if (deliv_q.size() >= n) break;
      step();
      settle();
    end
    chk(tag, 32'(deliv_q.size() >= n), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},  32'(bus.mem_req),    32'(0));
    chk({tag, "_addr"}, 32'(bus.mem_addr),   32'(RESET_PC));
    chk({tag, "_vld"},  32'(bus.inst_valid), 32'(0));
    chk({tag, "_inst"}, 32'(bus.inst),       32'(0));
    chk({tag, "_ipc"},  32'(bus.inst_pc),    32'(0));
  endtask

  logic [15:0] rp;

  initial begin
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // 1: zero-wait streaming after reset
    rand_mode = 1'b0; lat_fixed = 0; bus.inst_ready = 1'b1;
    do_reset();
    settle();
    chk_reset_outputs("t1_rst");
    step(); settle();
    chk("t1_req_rise", 32'(bus.mem_req),  32'(1));
    chk("t1_addr0",    32'(bus.mem_addr), 32'(0));
    for (int n = 2; n < 8; n++) begin
      step(); settle();
      chk("t1_vld",  32'(bus.inst_valid), 32'(1));
      chk("t1_ipc",  32'(bus.inst_pc),    32'(n - 2));
      chk("t1_inst", 32'(bus.inst),       32'(16'(n - 2) ^ XMASK));
    end

    // 2: decode stalled, FIFO fills and fetch stops, then drains in order
    bus.inst_ready = 1'b0;
    do_reset();
    deliv_q.delete();
    repeat (5) step();
    settle();
    chk("t2_req_off", 32'(bus.mem_req),    32'(0));
    chk("t2_vld",     32'(bus.inst_valid), 32'(1));
    chk("t2_head",    32'(bus.inst_pc),    32'(0));
    repeat (3) step();
    settle();
    chk("t2_req_still_off", 32'(bus.mem_req), 32'(0));
    step();
    bus.inst_ready = 1'b1;
    wait_deliv(4, 5, "t2_drain_time");
    for (int i = 0; i < 4; i++) begin
      if (i < deliv_q.size()) chk("t2_order", 32'(deliv_q[i]), 32'(i));
    end

    // 3: slow memory, redirect in second WAIT cycle
    lat_fixed = 3;
    do_reset();
    deliv_q.delete();
    step();
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    settle();
    chk("t3_req", 32'(bus.mem_req), 32'(1));
    step();
    bus.redirect = 1'b0;
    settle();
    chk("t3_drop_req",  32'(bus.mem_req),    32'(1));
    chk("t3_drop_addr", 32'(bus.mem_addr),   32'(0));
    chk("t3_drop_vld",  32'(bus.inst_valid), 32'(0));
    step(); settle();
    chk("t3_ack_addr", 32'(bus.mem_addr), 32'(0));
    step(); settle();
    chk("t3_idle", 32'(bus.mem_req), 32'(0));
    step();
    wait_deliv(2, 30, "t3_deliv_time");
    if (deliv_q.size() >= 2) begin
      chk("t3_first",  32'(deliv_q[0]), 32'(16'h0040));
      chk("t3_second", 32'(deliv_q[1]), 32'(16'h0041));
    end

    // 4: redirect coinciding with ack and pop
    lat_fixed = 0;
    do_reset();
    repeat (5) step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0200;
    settle();
    chk("t4_pre_vld", 32'(bus.inst_valid), 32'(1));
    chk("t4_pre_req", 32'(bus.mem_req),    32'(1));
    deliv_q.delete();
    step();
    bus.redirect = 1'b0;
    settle();
    chk("t4_flushed", 32'(bus.inst_valid), 32'(0));
    step();
    wait_deliv(2, 10, "t4_deliv_time");
    if (deliv_q.size() >= 2) begin
      chk("t4_first",  32'(deliv_q[0]), 32'(16'h0200));
      chk("t4_second", 32'(deliv_q[1]), 32'(16'h0201));
    end

    // 5: redirect to top of address space, PC wraps
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
    settle();
    deliv_q.delete();
    step();
    bus.redirect = 1'b0;
    wait_deliv(3, 15, "t5_deliv_time");
    if (deliv_q.size() >= 3) begin
      chk("t5_ffff", 32'(deliv_q[0]), 32'(16'hFFFF));
      chk("t5_0000", 32'(deliv_q[1]), 32'(16'h0000));
      chk("t5_0001", 32'(deliv_q[2]), 32'(16'h0001));
    end

    // 6: reset mid-WAIT with a stray ack right after
    step();
    lat_fixed = 3;
    repeat (6) step();
    settle();
    chk("t6_busy", 32'(bus.mem_req), 32'(1));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    stray_ack = 1'b1;
    settle();
    chk_reset_outputs("t6_rst");
    step();
    stray_ack = 1'b0;
    settle();
    chk("t6_restart_req",  32'(bus.mem_req),    32'(1));
    chk("t6_restart_addr", 32'(bus.mem_addr),   32'(RESET_PC));
    chk("t6_no_stray",     32'(bus.inst_valid), 32'(0));
    deliv_q.delete();
    step();
    wait_deliv(2, 30, "t6_deliv_time");
    if (deliv_q.size() >= 2) begin
      chk("t6_first",  32'(deliv_q[0]), 32'(RESET_PC));
      chk("t6_second", 32'(deliv_q[1]), 32'(RESET_PC + 16'd1));
    end

    // randomized traffic: random stalls, latencies and redirects
    rand_mode = 1'b1;
    deliv_q.delete();
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) begin
        rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        bus.redirect    = 1'b1;
        bus.redirect_pc = rp;
      end else begin
        bus.redirect = 1'b0;
      end
    end
    step();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (10) step();
    settle();
    chk("rnd_progress", 32'(deliv_q.size() > 500), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
